// File: rtl/led_blink_pkg.sv
`default_nettype none
// ============================================================================
// Package  : led_blink_pkg
// Brief    : Shared types and helpers for the led_blink memory self-test
//            master: FSM state encoding, test pattern generator, constants.
// Revision : 1.0 - initial release
// ============================================================================
package led_blink_pkg;

    // Test sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Byte enables presented with every command
    localparam logic [3:0]  BYTEEN_ALL = 4'hF;

    // Saturation point of the mismatch counter
    localparam logic [15:0] ERR_MAX    = 16'hFFFF;

    // Pattern word for index idx: upper half carries the index, lower half its
    // complement, so both stuck-at polarities are exercised on every bit lane
    function automatic logic [31:0] pat(input logic [31:0] seed,
                                        input logic [15:0] idx);
        return seed ^ {idx, ~idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_blink_rd_tracker.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_rd_tracker
// Brief    : Fixed-latency read tracker. Each accepted read enters a
//            LATENCY-deep valid/index shift register; the tail marks the
//            cycle in which the matching read data is on the bus.
// Revision : 1.0 - initial release
// ============================================================================
module led_blink_rd_tracker #(
    parameter int LATENCY = 1,
    parameter int IDX_W   = 17
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    output logic             cmp_valid,
    output logic [IDX_W-1:0] cmp_idx,
    output logic             pending
);

    logic [LATENCY-1:0]            r_valid;
    logic [LATENCY-1:0][IDX_W-1:0] r_idx;

    // Shift accepted reads toward the compare stage, one stage per cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_idx   <= '0;
        end else begin
            r_valid[0] <= push;
            r_idx[0]   <= push_idx;
            for (int s = 1; s < LATENCY; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_idx[s]   <= r_idx[s-1];
            end
        end
    end

    assign cmp_valid = r_valid[LATENCY-1];
    assign cmp_idx   = r_idx[LATENCY-1];

    // "pending" ignores the tail: the tail entry is consumed at the coming
    // edge, so the sequencer may leave DRAIN in that same cycle
    generate
        if (LATENCY > 1) begin : g_pend_deep
            assign pending = |r_valid[LATENCY-2:0];
        end else begin : g_pend_single
            assign pending = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/led_blink_mem_tester.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_mem_tester
// Brief    : Avalon-MM self-test master for the led_blink on-chip RAM.
//            Writes a seeded pattern over a wrapping address window, reads it
//            back and reports pass/fail, a saturating error count and the
//            address of the first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module led_blink_mem_tester #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [DATA_W-1:0] avm_writedata,
    output logic              avm_clken,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    import led_blink_pkg::*;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_idx;
    logic [31:0]       r_seed;
    logic [15:0]       r_err;
    logic [ADDR_W-1:0] r_first;
    logic              r_pass;

    logic              w_start_ok;
    logic              w_cmd;
    logic              w_accept;
    logic              w_last;
    logic              w_push;
    logic              w_cmp_valid;
    logic [ADDR_W:0]   w_cmp_idx;
    logic              w_pending;
    logic              w_mismatch;

    // Start is honoured only from IDLE; DONE and the busy states drop it
    assign w_start_ok = (r_state == IDLE) && start;
    assign w_cmd      = (r_state == WRITE) || (r_state == READ);
    assign w_accept   = w_cmd && !avm_waitrequest;
    assign w_last     = (r_idx == r_count - 1'b1);
    assign w_push     = (r_state == READ) && w_accept;

    // Bus command is decoded purely from registered state, so it stays
    // stable for as long as the slave stalls
    assign avm_chipselect = w_cmd;
    assign avm_write      = (r_state == WRITE);
    assign avm_byteenable = w_cmd ? BYTEEN_ALL : 4'h0;
    assign avm_address    = w_cmd ? ADDR_W'(r_base + r_idx[ADDR_W-1:0]) : '0;
    assign avm_writedata  = (r_state == WRITE) ? pat(r_seed, 16'(r_idx)) : '0;
    assign avm_clken      = 1'b1;

    assign busy           = (r_state == WRITE) || (r_state == READ) || (r_state == DRAIN);
    assign done           = (r_state == DONE);
    assign err_count      = r_err;
    assign first_err_addr = r_first;
    // The last compare lands on the edge entering DONE, so the verdict is
    // derived live during DONE and latched for the following idle period
    assign pass           = (r_state == DONE) ? (r_err == 16'h0) : r_pass;

    led_blink_rd_tracker #(
        .LATENCY (READ_LATENCY),
        .IDX_W   (ADDR_W + 1)
    ) u_rd_tracker (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_idx  (r_idx),
        .cmp_valid (w_cmp_valid),
        .cmp_idx   (w_cmp_idx),
        .pending   (w_pending)
    );

    assign w_mismatch = w_cmp_valid && (avm_readdata != pat(r_seed, 16'(w_cmp_idx)));

    // Sequencer: capture test parameters, walk the window for writes then reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_seed  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base  <= base_addr;
                        r_count <= word_count;
                        r_seed  <= seed;
                        r_idx   <= '0;
                        r_state <= (word_count == '0) ? DONE : WRITE;
                    end
                end
                WRITE: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= READ;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                READ: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_state <= DRAIN;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!w_pending) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Mismatch accounting; a zero count doubles as the "no error seen yet" flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err   <= '0;
            r_first <= '0;
        end else if (w_start_ok) begin
            r_err   <= '0;
            r_first <= '0;
        end else if (w_mismatch) begin
            if (r_err != ERR_MAX) begin
                r_err <= r_err + 16'h1;
            end
            if (r_err == 16'h0) begin
                r_first <= ADDR_W'(r_base + w_cmp_idx[ADDR_W-1:0]);
            end
        end
    end

    // Hold the verdict after DONE until the next accepted start clears it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pass <= 1'b0;
        end else if (w_start_ok) begin
            r_pass <= 1'b0;
        end else if (r_state == DONE) begin
            r_pass <= (r_err == 16'h0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_blink_mem_tester.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_blink_mem_tester
// Brief    : Self-checking bench for led_blink_mem_tester. One instance at
//            read latency 1 with a scoreboarded RAM model, one at latency 3
//            for the mid-test reset scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_blink_mem_tester;

    localparam int L1 = 1;
    localparam int L3 = 3;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
    } cmd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        start = 1'b0, start3 = 1'b0;
    logic [15:0] base_addr = '0;
    logic [16:0] word_count = '0;
    logic [31:0] seed = '0;

    logic        busy, done, pass, avm_chipselect, avm_write, avm_clken;
    logic [15:0] err_count, first_err_addr, avm_address;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;

    logic        busy3, done3, pass3, cs3, wr3, clken3;
    logic [15:0] err3, first3, addr3;
    logic [3:0]  be3;
    logic [31:0] wdata3;
    logic [31:0] rdata3 = '0;

    led_blink_mem_tester #(.ADDR_W(16), .DATA_W(32), .READ_LATENCY(L1)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .seed(seed), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr), .avm_address(avm_address),
        .avm_chipselect(avm_chipselect), .avm_write(avm_write), .avm_byteenable(avm_byteenable),
        .avm_writedata(avm_writedata), .avm_clken(avm_clken), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    led_blink_mem_tester #(.ADDR_W(16), .DATA_W(32), .READ_LATENCY(L3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .base_addr(base_addr),
        .word_count(word_count), .seed(seed), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_err_addr(first3), .avm_address(addr3),
        .avm_chipselect(cs3), .avm_write(wr3), .avm_byteenable(be3),
        .avm_writedata(wdata3), .avm_clken(clken3), .avm_readdata(rdata3),
        .avm_waitrequest(1'b0)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          n_stall = 0;
    int          n_done = 0;
    int          n_done3 = 0;
    bit          stall_en = 1'b0;
    bit          fault_en = 1'b0;
    cmd_t        cmd_q[$];
    logic [31:0] mem1 [65536];
    logic [31:0] mem3 [65536];
    logic [31:0] rd1_data [8];
    bit          rd1_vld [8];
    logic [31:0] rd3_data [8];
    bit          rd3_vld [8];
    bit          held_v = 1'b0;
    bit          held_wr;
    logic [15:0] held_addr;
    logic [31:0] held_data;

    function automatic logic [31:0] tb_pat(input logic [31:0] s, input int i);
        logic [15:0] lo;
        lo = i[15:0];
        return s ^ {lo, ~lo};
    endfunction

    // RAM model return path and stall generator, updated just after each edge
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        avm_readdata = rd1_vld[cyc % 8] ? rd1_data[cyc % 8] : 32'hDEAD_BEEF;
        rd1_vld[cyc % 8] = 1'b0;
        rdata3 = rd3_vld[cyc % 8] ? rd3_data[cyc % 8] : 32'hDEAD_BEEF;
        rd3_vld[cyc % 8] = 1'b0;
        avm_waitrequest = stall_en && ($urandom_range(0, 99) < 30);
    end

    // Bus monitor mid-cycle: scoreboard pop, stall stability, RAM model update
    always @(negedge clk) begin
        cmd_t exp;
        if (done)  n_done++;
        if (done3) n_done3++;
        if (reset_n && held_v) begin
            n_checks++;
            if ({avm_chipselect, avm_write, avm_address, avm_writedata} !== {1'b1, held_wr, held_addr, held_data})
                $display("FAIL stall_hold: got cs=%b wr=%b a=%h d=%h, need cs=1 wr=%b a=%h d=%h",
                         avm_chipselect, avm_write, avm_address, avm_writedata, held_wr, held_addr, held_data);
            else n_pass++;
        end
        held_v = 1'b0;
        if (reset_n && avm_chipselect) begin
            if (avm_waitrequest) begin
                held_v = 1'b1; held_wr = avm_write; held_addr = avm_address; held_data = avm_writedata;
                n_stall++;
            end else begin
                n_checks++;
                if (cmd_q.size() == 0) begin
                    $display("FAIL bus_cmd: unexpected wr=%b a=%h d=%h, need no command", avm_write, avm_address, avm_writedata);
                end else begin
                    exp = cmd_q.pop_front();
                    if (avm_write !== exp.wr || avm_address !== exp.addr || avm_byteenable !== 4'hF ||
                        (exp.wr && avm_writedata !== exp.data))
                        $display("FAIL bus_cmd: got wr=%b a=%h be=%h d=%h, need wr=%b a=%h be=f d=%h",
                                 avm_write, avm_address, avm_byteenable, avm_writedata, exp.wr, exp.addr, exp.data);
                    else n_pass++;
                end
                if (avm_write) begin
                    mem1[avm_address] = avm_writedata;
                end else begin
                    rd1_data[(cyc + L1) % 8] = mem1[avm_address] ^
                        {31'b0, fault_en && (avm_address == 16'h0005 || avm_address == 16'h0009)};
                    rd1_vld[(cyc + L1) % 8] = 1'b1;
                end
            end
        end
        if (reset_n && cs3) begin
            if (wr3) begin
                mem3[addr3] = wdata3;
            end else begin
                rd3_data[(cyc + L3) % 8] = mem3[addr3];
                rd3_vld[(cyc + L3) % 8] = 1'b1;
            end
        end
    end

    // Pulse start for one cycle; optionally queue the expected command stream
    task automatic do_start(input logic [15:0] b, input logic [16:0] n, input logic [31:0] s,
                            input bit on3, output int k);
        @(posedge clk); #3;
        base_addr = b; word_count = n; seed = s;
        if (on3) start3 = 1'b1;
        else begin
            start = 1'b1;
            for (int i = 0; i < int'(n); i++) cmd_q.push_back('{1'b1, 16'(b + i), tb_pat(s, i)});
            for (int i = 0; i < int'(n); i++) cmd_q.push_back('{1'b0, 16'(b + i), 32'h0});
        end
        @(posedge clk); #3;
        start = 1'b0; start3 = 1'b0;
        k = cyc;
    endtask

    // Bounded wait for done; d = -1 on expiry so the caller's timing check fails
    task automatic wait_done(input bit on3, input int budget, output int d);
        d = -1;
        for (int c = 0; c < budget; c++) begin
            if (on3 ? done3 : done) begin
                d = cyc;
                break;
            end
            @(posedge clk); #3;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #3;
        n_checks++;
        if ({busy, done, pass, err_count, first_err_addr, avm_address, avm_chipselect, avm_write,
             avm_byteenable, avm_writedata} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b pass=%b err=%h first=%h a=%h cs=%b wr=%b be=%h d=%h, need all 0",
                     busy, done, pass, err_count, first_err_addr, avm_address, avm_chipselect, avm_write,
                     avm_byteenable, avm_writedata);
        else n_pass++;
        n_checks++;
        if (avm_clken !== 1'b1) $display("FAIL reset_clken: got %b need 1", avm_clken);
        else n_pass++;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        n_checks++;
        if ({busy, done, pass, avm_chipselect, err_count} !== '0)
            $display("FAIL post_reset_idle: got busy=%b done=%b pass=%b cs=%b err=%h, need 0",
                     busy, done, pass, avm_chipselect, err_count);
        else n_pass++;
        n_checks++;
        if (avm_clken !== 1'b1) $display("FAIL post_reset_clken: got %b need 1", avm_clken);
        else n_pass++;
    endtask

    task automatic test_clean_pass();
        int k, d;
        do_start(16'h0000, 17'd16, 32'hA5A5_0000, 1'b0, k);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL clean_busy_start: got %b need 1", busy);
        else n_pass++;
        wait_done(1'b0, 100, d);
        n_checks++;
        if (d !== k + 33) $display("FAIL clean_done_cycle: got %0d need %0d", d - k + 1, 34);
        else n_pass++;
        n_checks++;
        if ({pass, err_count, first_err_addr, busy} !== {1'b1, 16'h0, 16'h0, 1'b0})
            $display("FAIL clean_result: got pass=%b err=%h first=%h busy=%b, need 1/0/0/0", pass, err_count, first_err_addr, busy);
        else n_pass++;
        n_checks++;
        if (cmd_q.size() != 0) $display("FAIL clean_cmds_left: got %0d need 0", cmd_q.size());
        else n_pass++;
    endtask

    task automatic test_wrap();
        int k, d;
        do_start(16'hFFFE, 17'd4, $urandom, 1'b0, k);
        wait_done(1'b0, 100, d);
        n_checks++;
        if (d !== k + 2 * 4 + L1) $display("FAIL wrap_done_cycle: got %0d need %0d", d, k + 2 * 4 + L1);
        else n_pass++;
        n_checks++;
        if ({pass, err_count} !== {1'b1, 16'h0}) $display("FAIL wrap_result: got pass=%b err=%h, need 1/0", pass, err_count);
        else n_pass++;
        n_checks++;
        if (cmd_q.size() != 0) $display("FAIL wrap_cmds_left: got %0d need 0", cmd_q.size());
        else n_pass++;
    endtask

    task automatic test_fault();
        int k, d, e_err;
        logic [15:0] e_first, a;
        fault_en = 1'b1;
        e_err = 0; e_first = '0;
        for (int i = 0; i < 16; i++) begin
            a = 16'(i);
            if (a == 16'h0005 || a == 16'h0009) begin
                if (e_err == 0) e_first = a;
                e_err++;
            end
        end
        do_start(16'h0000, 17'd16, 32'h1357_9BDF, 1'b0, k);
        wait_done(1'b0, 100, d);
        n_checks++;
        if (d !== k + 33) $display("FAIL fault_done_cycle: got %0d need %0d", d, k + 33);
        else n_pass++;
        n_checks++;
        if ({pass, err_count, first_err_addr} !== {e_err == 0, 16'(e_err), e_first})
            $display("FAIL fault_result: got pass=%b err=%h first=%h, need pass=%b err=%h first=%h",
                     pass, err_count, first_err_addr, e_err == 0, 16'(e_err), e_first);
        else n_pass++;
        @(posedge clk); #3;
        n_checks++;
        if ({pass, err_count} !== {1'b0, 16'(e_err)})
            $display("FAIL fault_hold: got pass=%b err=%h, need 0/%h", pass, err_count, 16'(e_err));
        else n_pass++;
        fault_en = 1'b0;
    endtask

    task automatic test_waitrequest();
        int k, d;
        n_stall = 0;
        stall_en = 1'b1;
        do_start(16'h0040, 17'd8, 32'hCAFE_F00D, 1'b0, k);
        wait_done(1'b0, 200, d);
        stall_en = 1'b0;
        n_checks++;
        if (d !== k + 2 * 8 + L1 + n_stall)
            $display("FAIL wait_done_cycle: got %0d need %0d (stalls %0d)", d, k + 2 * 8 + L1 + n_stall, n_stall);
        else n_pass++;
        n_checks++;
        if ({pass, err_count} !== {1'b1, 16'h0}) $display("FAIL wait_result: got pass=%b err=%h, need 1/0", pass, err_count);
        else n_pass++;
        n_checks++;
        if (cmd_q.size() != 0) $display("FAIL wait_cmds_left: got %0d need 0", cmd_q.size());
        else n_pass++;
    endtask

    task automatic test_zero_count();
        int k, d, n0;
        do_start(16'h1234, 17'd0, 32'h0, 1'b0, k);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL zero_busy: got %b need 0", busy);
        else n_pass++;
        wait_done(1'b0, 10, d);
        n_checks++;
        if (d !== k) $display("FAIL zero_done_cycle: got %0d need %0d", d, k);
        else n_pass++;
        n_checks++;
        if ({pass, err_count} !== {1'b1, 16'h0}) $display("FAIL zero_result: got pass=%b err=%h, need 1/0", pass, err_count);
        else n_pass++;
        start = 1'b1;
        @(posedge clk); #3;
        start = 1'b0;
        n0 = n_done;
        repeat (4) @(posedge clk);
        #3;
        n_checks++;
        if ({busy, 32'(n_done)} !== {1'b0, 32'(n0)})
            $display("FAIL start_on_done: got busy=%b dones=%0d, need busy=0 dones=%0d", busy, n_done, n0);
        else n_pass++;
    endtask

    task automatic test_ignored_start();
        int k, d, n0;
        n0 = n_done;
        do_start(16'h0200, 17'd8, 32'h0F0F_3C3C, 1'b0, k);
        repeat (3) @(posedge clk);
        #3;
        base_addr = 16'h7000; word_count = 17'd3; start = 1'b1;
        @(posedge clk); #3;
        start = 1'b0;
        wait_done(1'b0, 100, d);
        n_checks++;
        if (d !== k + 2 * 8 + L1) $display("FAIL busy_start_done_cycle: got %0d need %0d", d, k + 2 * 8 + L1);
        else n_pass++;
        n_checks++;
        if (pass !== 1'b1) $display("FAIL busy_start_pass: got %b need 1", pass);
        else n_pass++;
        repeat (8) @(posedge clk);
        #3;
        n_checks++;
        if (n_done != n0 + 1) $display("FAIL busy_start_single_done: got %0d need %0d", n_done - n0, 1);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int k, d, n0;
        bit in_read;
        do_start(16'h0100, 17'd16, 32'h8421_1248, 1'b1, k);
        in_read = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (cs3 && !wr3) begin
                in_read = 1'b1;
                break;
            end
            @(posedge clk); #3;
        end
        @(posedge clk); #3;
        n_checks++;
        if (in_read !== 1'b1) $display("FAIL mid_reach_read: got %b need 1", in_read);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy3, done3, pass3, err3, first3, addr3, cs3, wr3, be3, wdata3} !== '0)
            $display("FAIL mid_reset_outputs: got busy=%b done=%b pass=%b err=%h first=%h a=%h cs=%b wr=%b be=%h d=%h, need all 0",
                     busy3, done3, pass3, err3, first3, addr3, cs3, wr3, be3, wdata3);
        else n_pass++;
        n_checks++;
        if (clken3 !== 1'b1) $display("FAIL mid_reset_clken: got %b need 1", clken3);
        else n_pass++;
        n0 = n_done3;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        repeat (30) @(posedge clk);
        #3;
        n_checks++;
        if (n_done3 != n0) $display("FAIL mid_no_done: got %0d dones need 0", n_done3 - n0);
        else n_pass++;
        do_start(16'hFFF8, 17'd12, 32'h7777_0001, 1'b1, k);
        wait_done(1'b1, 100, d);
        n_checks++;
        if (d !== k + 2 * 12 + L3) $display("FAIL mid_rerun_done_cycle: got %0d need %0d", d, k + 2 * 12 + L3);
        else n_pass++;
        n_checks++;
        if ({pass3, err3} !== {1'b1, 16'h0}) $display("FAIL mid_rerun_result: got pass=%b err=%h, need 1/0", pass3, err3);
        else n_pass++;
    endtask

    // Hard stop so a hung handshake can never stall the run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout need completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_clean_pass();
        test_wrap();
        test_fault();
        test_waitrequest();
        test_zero_count();
        test_ignored_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
